// File: rtl/axi4l_mst_bridge.sv
// axi4l_mst_bridge: single-outstanding AXI4-Lite master for the core data path.
// Turns one valid/ready load/store into one AXI4-Lite transaction and response.
module axi4l_mst_bridge #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_e;

  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WD_EN ? TIMEOUT_CYC - 1 : 0);

  state_e state_q, state_d;

  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic wd_fire;
  logic unused_resp_lsb;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;
  assign b_hs  = bready_q & m_axi_bvalid;
  assign ar_hs = arvalid_q & m_axi_arready;
  assign r_hs  = rready_q & m_axi_rvalid;

  // Only the error bit of the response codes matters here.
  assign unused_resp_lsb = ^{m_axi_bresp[0], m_axi_rresp[0]};

  // Watchdog expiry; a completing handshake in the same cycle takes priority.
  assign wd_fire = WD_EN
                && (state_q != S_IDLE)
                && (cnt_q == CNT_LAST)
                && !(b_hs || r_hs);

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = S_WRESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          state_d      = S_IDLE;
          bready_d     = 1'b0;
          err_d        = m_axi_bresp[1];
          resp_valid_d = 1'b1;
        end
      end
      S_RADDR: begin
        if (ar_hs) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          state_d      = S_IDLE;
          rready_d     = 1'b0;
          rdata_d      = m_axi_rdata;
          err_d        = m_axi_rresp[1];
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wd_fire) begin
      state_d      = S_IDLE;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      aw_done_d    = 1'b0;
      w_done_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      rdata_d      = rdata_q;
      err_d        = 1'b1;
      resp_valid_d = 1'b1;
    end
  end

  // Watchdog counts every non-idle cycle and restarts with each transaction.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_mst_bridge.sv
// tb_axi4l_mst_bridge: scoreboard bench with a latency-configurable slave.
// Expected responses come from a word-level memory model and timeout rule.
module tb_axi4l_mst_bridge;

  localparam int TO = 8;

  typedef struct {
    int aw;
    int w;
    int b;
    int ar;
    int r;
    int hang;
    logic [1:0] bresp;
    logic [1:0] rresp;
  } cfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axi4l_mst_bridge #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int resp_cyc = -1;
  int issue_cyc = -1;

  exp_t sb[$];
  logic [31:0] model_mem [16];
  logic [31:0] model_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  cfg_t cfg;
  logic [31:0] slv_mem [16];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  assign awready = awvalid && !aw_got && (aw_cnt >= cfg.aw) && (cfg.hang != 1);
  assign wready  = wvalid && !w_got && (w_cnt >= cfg.w) && (cfg.hang != 2);
  assign bvalid  = b_pend && (b_cnt >= cfg.b) && (cfg.hang != 3);
  assign arready = arvalid && (ar_cnt >= cfg.ar) && (cfg.hang != 4);
  assign rvalid  = r_pend && (r_cnt >= cfg.r) && (cfg.hang != 5);
  assign bresp   = cfg.bresp;
  assign rresp   = cfg.rresp;
  assign rdata   = s_rdata;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end
    if (rst || req_ready) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))
          && !b_pend) begin
        b_pend <= 1'b1; b_cnt <= 0;
      end
      if (bvalid && bready) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) slv_mem[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        b_pend <= 1'b0;
      end else if (b_pend) b_cnt <= b_cnt + 1;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
        s_rdata <= slv_mem[araddr[5:2]];
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) r_pend <= 1'b0;
      else if (r_pend) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resp_valid) begin
      exp_t e;
      resp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // Address/data must not move while a valid is held.
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  always @(negedge clk) begin
    if (!rst && p_aw && awvalid) chk("awaddr_stable", awaddr, p_awaddr);
    if (!rst && p_w && wvalid)   chk("wdata_stable", wdata, p_wdata);
    if (!rst && p_ar && arvalid) chk("araddr_stable", araddr, p_araddr);
    p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
    p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
  end

  // ---------------- driver + reference model ----------------
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input cfg_t c, input bit push);
    int n;
    int wa;
    bit to;
    exp_t e;
    logic [3:0] idx;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    cfg = c;
    issue_cyc = cyc;
    req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    req_valid = 1'b1;
    idx = addr[5:2];
    if (we) begin
      wa = ((c.aw > c.w) ? c.aw : c.w) + 1;
      to = (c.hang == 1) || (c.hang == 2) || (c.hang == 3)
        || (wa + c.b + 1 > TO);
      if (!to)
        for (int i = 0; i < 4; i++)
          if (st[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
      e.rdata = model_last;
      e.err = to ? 1'b1 : c.bresp[1];
    end else begin
      to = (c.hang == 4) || (c.hang == 5) || (c.ar + 1 + c.r + 1 > TO);
      if (to) begin
        e.rdata = model_last;
        e.err = 1'b1;
      end else begin
        e.rdata = model_mem[idx];
        e.err = c.rresp[1];
        model_last = e.rdata;
      end
    end
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  function automatic cfg_t mk(int aw, int w, int b, int ar, int r, int hang,
                              logic [1:0] br, logic [1:0] rr);
    cfg_t c;
    c.aw = aw; c.w = w; c.b = b; c.ar = ar; c.r = r; c.hang = hang;
    c.bresp = br; c.rresp = rr;
    return c;
  endfunction

  initial begin
    cfg_t c0;
    cfg_t c;
    int k;
    int acc;
    c0 = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    cfg = c0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    model_last = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valids", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", awaddr | wdata | {28'b0, wstrb}, 32'd0);
    rst = 1'b0;

    // Zero-wait write: AW/W together in cycle 1, response in cycle 3.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, c0, 1'b1);
    @(negedge clk);
    chk("wr_aw_w_cycle1", {30'b0, awvalid, wvalid}, 32'd3);
    chk("wr_awaddr", awaddr, 32'h10);
    @(negedge clk);
    chk("wr_no_resp_cycle2", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("wr_resp_cycle3", {31'b0, resp_valid}, 32'd1);
    chk("slv_mem4", slv_mem[4], 32'hDEADBEEF);

    // Read back, then a second read issued in the response cycle.
    issue(1'b0, 32'h10, 32'h0, 4'h0, c0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, c0, 1'b1);
    chk("b2b_accept_cycle", 32'(issue_cyc), 32'(resp_cyc));

    // W lags AW by three cycles.
    c = mk(0, 3, 0, 0, 0, 0, 2'b00, 2'b00);
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, c, 1'b1);
    @(negedge clk);
    chk("slow_w_c1", {30'b0, awvalid, wvalid}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("slow_w_hold", {30'b0, awvalid, wvalid}, 32'd1);
      chk("slow_w_data", wdata, 32'h12345678);
    end
    @(negedge clk);
    chk("slow_w_done", {30'b0, awvalid, wvalid}, 32'd0);

    // Error responses.
    c = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10);
    issue(1'b0, 32'h20, 32'h0, 4'h0, c, 1'b1);
    c = mk(1, 0, 1, 0, 0, 0, 2'b11, 2'b00);
    issue(1'b1, 32'h24, 32'hCAFEF00D, 4'b0110, c, 1'b1);

    // AR never accepted: watchdog completes with an error.
    c = mk(0, 0, 0, 0, 0, 4, 2'b00, 2'b00);
    issue(1'b0, 32'h10, 32'h0, 4'h0, c, 1'b1);
    k = 0;
    acc = 0;
    while (!resp_valid && acc < 40) begin
      @(negedge clk);
      if (arvalid) k++;
      acc++;
    end
    chk("to_arvalid_cycles", 32'(k), 32'd8);
    chk("to_idle", {30'b0, req_ready, arvalid}, 32'd2);

    // Completion in the watchdog's last cycle wins; one cycle later loses.
    issue(1'b0, 32'h24, 32'h0, 4'h0, mk(0, 0, 0, 3, 3, 0, 2'b00, 2'b00), 1'b1);
    issue(1'b0, 32'h20, 32'h0, 4'h0, mk(0, 0, 0, 3, 4, 0, 2'b00, 2'b00), 1'b1);
    issue(1'b1, 32'h28, 32'h0BADC0DE, 4'hF, mk(3, 1, 3, 0, 0, 0, 2'b00, 2'b00), 1'b1);
    issue(1'b1, 32'h2C, 32'h55AA55AA, 4'hF, mk(3, 1, 4, 0, 0, 0, 2'b00, 2'b00), 1'b1);
    issue(1'b0, 32'h28, 32'h0, 4'h0, c0, 1'b1);
    issue(1'b0, 32'h2C, 32'h0, 4'h0, c0, 1'b1);

    // Reset in the middle of a write aborts it silently.
    c = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    issue(1'b1, 32'h30, 32'h11112222, 4'hF, c, 1'b0);
    @(negedge clk);
    chk("rst_mid_awvalid", {31'b0, awvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    chk("rst_mid_valids", {29'b0, awvalid, wvalid, arvalid}, 32'd0);
    chk("rst_mid_ready", {30'b0, req_ready, resp_valid}, 32'd2);
    @(negedge clk);
    chk("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic we;
      we = 1'(($urandom & 1));
      c = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 4), 0,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) c.hang = $urandom_range(1, 5);
      issue(we, {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            4'($urandom_range(0, 15)), c, 1'b1);
    end

    acc = 0;
    while (sb.size() != 0 && acc < 50) begin
      @(negedge clk);
      acc++;
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
